decode_stage: RTL and testbench



---
 rtl/decode_stage_if.sv | 51 +++++
 rtl/decode_stage.sv | 239 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side signals of decode_stage, bundled with master (driver) and slave (stage) views.
// Handshake: a beat moves on a rising edge where valid & ready; the sender holds valid and payload until then.
interface decode_stage_if #(
   parameter int XLEN           = 32,
   parameter int REG_BITS       = 5,
   parameter int STALL_CNT_BITS = 16
) ();
   logic                      in_valid;
   logic                      in_ready;
   logic [31:0]               in_instr;
   logic [XLEN-1:0]           in_pc;
   logic                      flush;

   logic                      out_valid;
   logic                      out_ready;
   logic [XLEN-1:0]           out_pc;
   logic [REG_BITS-1:0]       a0;
   logic [REG_BITS-1:0]       a1;
   logic [REG_BITS-1:0]       a2;
   logic [XLEN-1:0]           imm;
   logic [9:0]                func;
   logic                      en_jmp;
   logic                      en_uncond_jmp;
   logic                      en_rel_reg_jmp;
   logic                      en_imm;
   logic                      en_reg_wr;
   logic                      en_mem_wr;
   logic                      en_mem_re;
   logic                      dmem_addr_bus_use;
   logic [2:0]                ld_code;
   logic                      illegal;
   logic                      is_muldiv;
   logic [STALL_CNT_BITS-1:0] stall_cnt;
   logic [1:0]                dbg_state;

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, a0, a1, a2, imm, func,
             en_jmp, en_uncond_jmp, en_rel_reg_jmp, en_imm, en_reg_wr,
             en_mem_wr, en_mem_re, dmem_addr_bus_use, ld_code, illegal,
             is_muldiv, stall_cnt, dbg_state
   );

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, a0, a1, a2, imm, func,
             en_jmp, en_uncond_jmp, en_rel_reg_jmp, en_imm, en_reg_wr,
             en_mem_wr, en_mem_re, dmem_addr_bus_use, ld_code, illegal,
             is_muldiv, stall_cnt, dbg_state
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into an output register backed by one skid entry.
// Optional M-extension recognition is enabled by defining MUL_DIV_EN.
module decode_stage #(
   parameter int XLEN           = 32,
   parameter int REG_BITS       = 5,
   parameter int STALL_CNT_BITS = 16
) (
   input logic           clk,
   input logic           rst,
   decode_stage_if.slave bus
);
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_OP     = 7'h33;

   localparam logic [2:0] LD_NO      = 3'd0;
   localparam logic [2:0] LD_ALU     = 3'd1;
   localparam logic [2:0] LD_MEM     = 3'd2;
   localparam logic [2:0] LD_IMM     = 3'd3;
   localparam logic [2:0] LD_PC      = 3'd4;
   localparam logic [2:0] LD_PC_PIMM = 3'd5;

   typedef struct packed {
      logic [XLEN-1:0]     pc;
      logic [REG_BITS-1:0] a0;
      logic [REG_BITS-1:0] a1;
      logic [REG_BITS-1:0] a2;
      logic [XLEN-1:0]     imm;
      logic [9:0]          func;
      logic                en_jmp;
      logic                en_uncond_jmp;
      logic                en_rel_reg_jmp;
      logic                en_imm;
      logic                en_reg_wr;
      logic                en_mem_wr;
      logic                en_mem_re;
      logic                dmem_addr_bus_use;
      logic [2:0]          ld_code;
      logic                illegal;
      logic                is_muldiv;
   } entry_t;

   // S_ONE: output register holds an entry; S_FULL: skid entry holds one more.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t                    state;
   state_t                    state_nx;
   entry_t                    dec;
   entry_t                    out_q;
   entry_t                    skid_q;
   logic [STALL_CNT_BITS-1:0] stall_q;
   logic                      legal;
   logic                      in_ready_i;
   logic                      out_valid_i;
   logic                      in_xfer;
   logic                      out_xfer;
   logic                      load_out_new;
   logic                      load_out_skid;
   logic                      load_skid;

   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;

   assign instr  = bus.in_instr;
   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   always_comb begin
      dec       = '0;
      legal     = 1'b1;
      dec.pc    = bus.in_pc;
      dec.a0    = instr[19:15];
      dec.a1    = instr[24:20];
      dec.a2    = instr[11:7];
      dec.func  = {funct7, funct3};
      case (opcode)
         OPC_LUI: begin
            dec.imm       = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
            dec.ld_code   = LD_IMM;
            dec.en_reg_wr = 1'b1;
         end
         OPC_AUIPC: begin
            dec.imm       = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
            dec.ld_code   = LD_PC_PIMM;
            dec.en_reg_wr = 1'b1;
         end
         OPC_JAL: begin
            dec.imm           = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            dec.ld_code       = LD_PC;
            dec.en_jmp        = 1'b1;
            dec.en_uncond_jmp = 1'b1;
            dec.en_imm        = 1'b1;
            dec.en_reg_wr     = 1'b1;
         end
         OPC_JALR: begin
            dec.imm            = {{(XLEN-11){instr[31]}}, instr[30:20]};
            dec.ld_code        = LD_PC;
            dec.en_jmp         = 1'b1;
            dec.en_rel_reg_jmp = 1'b1;
            dec.en_imm         = 1'b1;
            dec.en_reg_wr      = 1'b1;
            legal              = (funct3 == 3'd0);
         end
         OPC_LOAD: begin
            dec.imm               = {{(XLEN-11){instr[31]}}, instr[30:20]};
            dec.func              = '0;
            dec.ld_code           = LD_MEM;
            dec.en_imm            = 1'b1;
            dec.en_reg_wr         = 1'b1;
            dec.en_mem_re         = 1'b1;
            dec.dmem_addr_bus_use = 1'b1;
            legal = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2) ||
                    (funct3 == 3'd4) || (funct3 == 3'd5);
         end
         OPC_STORE: begin
            dec.imm               = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
            dec.func              = '0;
            dec.ld_code           = LD_NO;
            dec.en_imm            = 1'b1;
            dec.en_mem_wr         = 1'b1;
            dec.dmem_addr_bus_use = 1'b1;
            legal                 = (funct3 <= 3'd2);
         end
         OPC_BRANCH: begin
            dec.imm     = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            dec.ld_code = LD_NO;
            dec.en_jmp  = 1'b1;
            legal       = (funct3 != 3'd2) && (funct3 != 3'd3);
         end
         OPC_OPIMM: begin
            dec.imm       = {{(XLEN-11){instr[31]}}, instr[30:20]};
            dec.ld_code   = LD_ALU;
            dec.en_imm    = 1'b1;
            dec.en_reg_wr = 1'b1;
         end
         OPC_OP: begin
            dec.ld_code   = LD_ALU;
            dec.en_reg_wr = 1'b1;
`ifdef MUL_DIV_EN
            dec.is_muldiv = (funct7 == 7'h01);
            legal = (funct7 == 7'h00) || (funct7 == 7'h20) || (funct7 == 7'h01);
`else
            legal = (funct7 == 7'h00) || (funct7 == 7'h20);
`endif
         end
         default: legal = 1'b0;
      endcase
      // Illegal entries must never write state or redirect the fetch stream.
      if (!legal) begin
         dec.illegal   = 1'b1;
         dec.en_reg_wr = 1'b0;
         dec.en_mem_wr = 1'b0;
         dec.en_mem_re = 1'b0;
         dec.en_jmp    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_EMPTY;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (bus.flush) begin
         state_nx = S_EMPTY;
      end else begin
         case (state)
            S_EMPTY: if (in_xfer) state_nx = S_ONE;
            S_ONE: begin
               if (in_xfer && !out_xfer)      state_nx = S_FULL;
               else if (!in_xfer && out_xfer) state_nx = S_EMPTY;
            end
            S_FULL:  if (out_xfer) state_nx = S_ONE;
            default: state_nx = S_EMPTY;
         endcase
      end
   end

   // in_ready comes straight from the state register, so out_ready never reaches it combinationally.
   always_comb begin
      in_ready_i    = (state != S_FULL);
      out_valid_i   = (state != S_EMPTY);
      in_xfer       = bus.in_valid & in_ready_i & ~bus.flush;
      out_xfer      = out_valid_i & bus.out_ready;
      load_out_new  = in_xfer & ((state == S_EMPTY) | out_xfer);
      load_out_skid = ~bus.flush & (state == S_FULL) & out_xfer;
      load_skid     = in_xfer & (state == S_ONE) & ~out_xfer;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= '0;
         skid_q  <= '0;
         stall_q <= '0;
      end else begin
         if (load_out_new)       out_q <= dec;
         else if (load_out_skid) out_q <= skid_q;
         if (load_skid)          skid_q <= dec;
         if (out_valid_i && !bus.out_ready && (stall_q != {STALL_CNT_BITS{1'b1}}))
            stall_q <= stall_q + STALL_CNT_BITS'(1);
      end
   end

   assign bus.in_ready          = in_ready_i;
   assign bus.out_valid         = out_valid_i;
   assign bus.out_pc            = out_q.pc;
   assign bus.a0                = out_q.a0;
   assign bus.a1                = out_q.a1;
   assign bus.a2                = out_q.a2;
   assign bus.imm               = out_q.imm;
   assign bus.func              = out_q.func;
   assign bus.en_jmp            = out_q.en_jmp;
   assign bus.en_uncond_jmp     = out_q.en_uncond_jmp;
   assign bus.en_rel_reg_jmp    = out_q.en_rel_reg_jmp;
   assign bus.en_imm            = out_q.en_imm;
   assign bus.en_reg_wr         = out_q.en_reg_wr;
   assign bus.en_mem_wr         = out_q.en_mem_wr;
   assign bus.en_mem_re         = out_q.en_mem_re;
   assign bus.dmem_addr_bus_use = out_q.dmem_addr_bus_use;
   assign bus.ld_code           = out_q.ld_code;
   assign bus.illegal           = out_q.illegal;
   assign bus.is_muldiv         = out_q.is_muldiv;
   assign bus.stall_cnt         = stall_q;
   assign bus.dbg_state         = state;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 2-deep queue model checked every cycle plus literal spot checks.
module tb_decode_stage;
   localparam int XLEN = 32;
   localparam int RB   = 5;
   localparam int SCB  = 6;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] imm;
      logic [9:0]  func;
      logic        en_jmp;
      logic        en_uncond_jmp;
      logic        en_rel_reg_jmp;
      logic        en_imm;
      logic        en_reg_wr;
      logic        en_mem_wr;
      logic        en_mem_re;
      logic        dmem_addr_bus_use;
      logic [2:0]  ld_code;
      logic        illegal;
      logic        is_muldiv;
   } ent_t;
   localparam int EW = $bits(ent_t);

   logic           clk = 1'b0;
   logic           rst;
   int             total = 0;
   int             bad = 0;
   logic [EW-1:0]  exp_q[$];
   logic [SCB-1:0] m_stall = '0;

   decode_stage_if #(.XLEN(XLEN), .REG_BITS(RB), .STALL_CNT_BITS(SCB)) bus ();

   decode_stage #(.XLEN(XLEN), .REG_BITS(RB), .STALL_CNT_BITS(SCB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode from the ISA rules, immediates built by arithmetic on field values.
   function automatic ent_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
      ent_t       e;
      int         v;
      bit         ok;
      logic [2:0] f3;
      logic [6:0] f7;
      e  = '0;
      ok = 1'b1;
      v  = 0;
      f3 = ins[14:12];
      f7 = ins[31:25];
      e.pc = pc; e.a0 = ins[19:15]; e.a1 = ins[24:20]; e.a2 = ins[11:7];
      e.func = {f7, f3};
      case (ins[6:0])
         7'h37: begin v = int'(ins & 32'hFFFF_F000); e.en_reg_wr = 1; e.ld_code = 3; end
         7'h17: begin v = int'(ins & 32'hFFFF_F000); e.en_reg_wr = 1; e.ld_code = 5; end
         7'h6F: begin
            v = (ins[31] ? -1048576 : 0) + (int'(ins[19:12]) << 12) + (int'(ins[20]) << 11) + (int'(ins[30:21]) << 1);
            e.en_jmp = 1; e.en_uncond_jmp = 1; e.en_imm = 1; e.en_reg_wr = 1; e.ld_code = 4;
         end
         7'h67: begin
            v = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
            e.en_jmp = 1; e.en_rel_reg_jmp = 1; e.en_imm = 1; e.en_reg_wr = 1; e.ld_code = 4;
            ok = (f3 == 3'd0);
         end
         7'h03: begin
            v = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
            e.func = '0; e.ld_code = 2; e.en_imm = 1; e.en_reg_wr = 1; e.en_mem_re = 1; e.dmem_addr_bus_use = 1;
            ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
         end
         7'h23: begin
            v = (ins[31] ? -2048 : 0) + (int'(ins[30:25]) << 5) + int'(ins[11:7]);
            e.func = '0; e.en_imm = 1; e.en_mem_wr = 1; e.dmem_addr_bus_use = 1;
            ok = f3 inside {3'd0, 3'd1, 3'd2};
         end
         7'h63: begin
            v = (ins[31] ? -4096 : 0) + (int'(ins[7]) << 11) + (int'(ins[30:25]) << 5) + (int'(ins[11:8]) << 1);
            e.en_jmp = 1;
            ok = !(f3 inside {3'd2, 3'd3});
         end
         7'h13: begin
            v = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
            e.en_imm = 1; e.en_reg_wr = 1; e.ld_code = 1;
         end
         7'h33: begin
            e.en_reg_wr = 1; e.ld_code = 1;
            ok = (f7 == 7'h00) || (f7 == 7'h20);
`ifdef MUL_DIV_EN
            if (f7 == 7'h01) begin ok = 1'b1; e.is_muldiv = 1; end
`endif
         end
         default: ok = 1'b0;
      endcase
      e.imm = v;
      if (!ok) begin
         e.illegal = 1; e.en_reg_wr = 0; e.en_mem_wr = 0; e.en_mem_re = 0; e.en_jmp = 0;
      end
      return e;
   endfunction

   function automatic ent_t dut_ent();
      ent_t d;
      d.pc = bus.out_pc; d.a0 = bus.a0; d.a1 = bus.a1; d.a2 = bus.a2;
      d.imm = bus.imm; d.func = bus.func;
      d.en_jmp = bus.en_jmp; d.en_uncond_jmp = bus.en_uncond_jmp;
      d.en_rel_reg_jmp = bus.en_rel_reg_jmp; d.en_imm = bus.en_imm;
      d.en_reg_wr = bus.en_reg_wr; d.en_mem_wr = bus.en_mem_wr;
      d.en_mem_re = bus.en_mem_re; d.dmem_addr_bus_use = bus.dmem_addr_bus_use;
      d.ld_code = bus.ld_code; d.illegal = bus.illegal; d.is_muldiv = bus.is_muldiv;
      return d;
   endfunction

   // Model: a FIFO of at most two decoded entries; the head is what the outputs show.
   always @(posedge clk) begin
      bit had_room;
      bit had_head;
      if (rst) begin
         exp_q.delete();
         m_stall = '0;
      end else begin
         had_room = (exp_q.size() < 2);
         had_head = (exp_q.size() > 0);
         if (had_head && !bus.out_ready && m_stall != {SCB{1'b1}}) m_stall = m_stall + 1'b1;
         if (had_head && bus.out_ready) void'(exp_q.pop_front());
         if (bus.flush) exp_q.delete();
         else if (bus.in_valid && had_room) exp_q.push_back(model_decode(bus.in_instr, bus.in_pc));
      end
   end

   // scoreboard compare
   always @(negedge clk) begin
      check("out_valid", bus.out_valid, exp_q.size() > 0);
      check("in_ready", bus.in_ready, exp_q.size() < 2);
      check("stall_cnt", bus.stall_cnt, m_stall);
      if (exp_q.size() > 0) check("entry", dut_ent(), exp_q[0]);
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [31:0] ins, input logic [31:0] pc);
      int n;
      n = 0;
      bus.in_valid = 1'b1; bus.in_instr = ins; bus.in_pc = pc;
      while (!bus.in_ready && n < 20) begin tick(); n++; end
      check("push_wait", n < 20, 1'b1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      ent_t        e;
      logic [31:0] mix [12];
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
      bus.flush = 1'b0; bus.out_ready = 1'b1;
      tick(); tick();
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_stall", bus.stall_cnt, 0);
      check("rst_payload", dut_ent(), '0);
      rst = 1'b0;

      e = model_decode(32'hFFF10093, 32'h100);
      check("pin_addi_imm", e.imm, 32'hFFFF_FFFF);
      check("pin_addi_func", e.func, 10'h3F8);
      e = model_decode(32'h00208463, 32'h0);
      check("pin_beq_imm", e.imm, 32'd8);
      e = model_decode(32'h123452B7, 32'h0);
      check("pin_lui_imm", e.imm, 32'h1234_5000);
      e = model_decode(32'hFFDFF0EF, 32'h0);
      check("pin_jal_imm", e.imm, 32'hFFFF_FFFC);
      e = model_decode(32'hFE20AC23, 32'h0);
      check("pin_sw_imm", e.imm, 32'hFFFF_FFF8);

      push(32'hFFF10093, 32'h100);
      check("addi_valid", bus.out_valid, 1);
      check("addi_pc", bus.out_pc, 32'h100);
      check("addi_a0", bus.a0, 2);
      check("addi_a2", bus.a2, 1);
      check("addi_imm", bus.imm, 32'hFFFF_FFFF);
      check("addi_func", bus.func, 10'h3F8);
      check("addi_ld", bus.ld_code, 1);
      check("addi_flags", {bus.en_imm, bus.en_reg_wr, bus.illegal}, 3'b110);

      push(32'h123452B7, 32'h104);
      check("lui_imm", bus.imm, 32'h1234_5000);
      check("lui_a2", bus.a2, 5);
      check("lui_ld", bus.ld_code, 3);

      push(32'h00208463, 32'h108);
      check("beq_imm", bus.imm, 32'd8);
      check("beq_jmp_wr", {bus.en_jmp, bus.en_reg_wr}, 2'b10);
      check("beq_ld", bus.ld_code, 0);
      tick();

      // backpressure: three offers on consecutive cycles
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_instr = 32'h00100093; bus.in_pc = 32'h300;
      tick();
      bus.in_instr = 32'h00200113; bus.in_pc = 32'h304;
      tick();
      bus.in_instr = 32'h00300193; bus.in_pc = 32'h308;
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_stall1", bus.stall_cnt, 1);
      tick(); tick();
      check("bp_stall3", bus.stall_cnt, 3);
      check("bp_hold_pc", bus.out_pc, 32'h300);
      bus.out_ready = 1'b1;
      tick();
      check("bp_skid_pc", bus.out_pc, 32'h304);
      check("bp_ready_back", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      check("bp_third_pc", bus.out_pc, 32'h308);
      tick();
      check("bp_drained", bus.out_valid, 0);

      // flush with both entries held and an offer pending
      bus.out_ready = 1'b0;
      push(32'h00400213, 32'h400);
      push(32'h00500293, 32'h404);
      bus.in_valid = 1'b1; bus.in_instr = 32'h00600313; bus.in_pc = 32'h408;
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      check("flush_valid", bus.out_valid, 0);
      check("flush_ready", bus.in_ready, 1);
      bus.out_ready = 1'b1;
      tick(); tick(); tick();
      check("flush_nothing", bus.out_valid, 0);

      mix = '{32'h00000517, 32'hFFDFF0EF, 32'h000080E7, 32'h0040A103,
              32'hFE20AC23, 32'h40208033, 32'h4010D093, 32'h00003003,
              32'h0000B023, 32'h0020A063, 32'h00009067, 32'h7E208033};
      for (int i = 0; i < 12; i++) begin
         bus.out_ready = (i % 3 != 2);
         push(mix[i], 32'h200 + 32'(4 * i));
      end
      bus.out_ready = 1'b1;
      tick(); tick(); tick();

      push(32'h022081B3, 32'h500);
`ifdef MUL_DIV_EN
      check("mul_muldiv", bus.is_muldiv, 1);
      check("mul_illegal", bus.illegal, 0);
`else
      check("mul_illegal", bus.illegal, 1);
      check("mul_reg_wr", bus.en_reg_wr, 0);
      check("mul_muldiv", bus.is_muldiv, 0);
`endif
      push(32'h0000007F, 32'h504);
      check("bad_op_illegal", bus.illegal, 1);
      check("bad_op_flags", {bus.en_jmp, bus.en_uncond_jmp, bus.en_rel_reg_jmp, bus.en_imm,
                             bus.en_reg_wr, bus.en_mem_wr, bus.en_mem_re, bus.dmem_addr_bus_use}, 8'h00);
      check("bad_op_ld", bus.ld_code, 0);
      tick();

      // reset mid-stream with both entries held
      bus.out_ready = 1'b0;
      push(32'h00700393, 32'h600);
      push(32'h00800413, 32'h604);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_valid", bus.out_valid, 0);
      check("mrst_ready", bus.in_ready, 1);
      check("mrst_stall", bus.stall_cnt, 0);
      check("mrst_payload", dut_ent(), '0);

      // stall counter saturation, untouched by flush
      push(32'h00900493, 32'h700);
      repeat (70) tick();
      check("stall_sat", bus.stall_cnt, {SCB{1'b1}});
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("stall_keep", bus.stall_cnt, {SCB{1'b1}});
      bus.out_ready = 1'b1;
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
